// File: rtl/dma_uart_pkg.sv
// Shared types for the DMA UART host memory: command byte layout, fp16 word type,
// host FSM state encoding and fp16 <-> cherry_float repacking helpers.
package dma_uart_pkg;

    localparam int DMA_ADDR_W     = 7;
    localparam int DMA_CMD_WE_BIT = 7;
    localparam int DMA_DEPTH      = 1 << DMA_ADDR_W;

    typedef logic [15:0] fp16_t;

    typedef struct packed {
        logic                  we;
        logic [DMA_ADDR_W-1:0] addr;
    } cmd_t;

    // cherry_float keeps the fp16 fields but exposes them by name.
    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } cherry_float_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MSB,
        ST_WR_LSB,
        ST_RD_FETCH,
        ST_RD_MSB_0,
        ST_RD_MSB_1,
        ST_RD_MSB_2,
        ST_RD_LSB_0,
        ST_RD_LSB_1,
        ST_RD_LSB_2
    } host_state_t;

    function automatic cherry_float_t fp16_to_cherry(input fp16_t f);
        cherry_float_t c;
        c.sign = f[15];
        c.exp  = f[14:10];
        c.frac = f[9:0];
        return c;
    endfunction

    function automatic fp16_t cherry_to_fp16(input cherry_float_t c);
        return {c.sign, c.exp, c.frac};
    endfunction

endpackage

// File: rtl/dma_uart_host_mem_uart_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, falling-edge start detect, mid-bit sampling.
// Emits a 1-cycle rx_valid on a good stop bit or rx_frame_err on a low stop bit.
module uart_rx #(
    parameter int CLK_HZ   = 50000000,
    parameter int BIT_RATE = 4800
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_frame_err
);
    localparam int CPB   = CLK_HZ / BIT_RATE;
    localparam int CNT_W = $clog2(CPB + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state_reg;
    logic [1:0]       sync_reg;
    logic             prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       idx_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       data_reg;
    logic             valid_reg;
    logic             err_reg;

    wire rx_bit  = sync_reg[1];
    wire bit_end = (cnt_reg == CNT_W'(CPB - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= RX_IDLE;
            sync_reg  <= 2'b11;
            prev_reg  <= 1'b1;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], rxd};
            prev_reg  <= rx_bit;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= cnt_reg + 1'b1;
            case (state_reg)
                RX_IDLE: begin
                    cnt_reg <= '0;
                    // Edge, not level: after a bad stop bit the line may still be low.
                    if (prev_reg && !rx_bit) state_reg <= RX_START;
                end
                RX_START: if (cnt_reg == CNT_W'(CPB / 2 - 1)) begin
                    cnt_reg   <= '0;
                    idx_reg   <= '0;
                    state_reg <= rx_bit ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (bit_end) begin
                    cnt_reg   <= '0;
                    shift_reg <= {rx_bit, shift_reg[7:1]};
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == 3'd7) state_reg <= RX_STOP;
                end
                default: if (bit_end) begin
                    cnt_reg   <= '0;
                    state_reg <= RX_IDLE;
                    if (rx_bit) begin
                        valid_reg <= 1'b1;
                        data_reg  <= shift_reg;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign rx_valid     = valid_reg;
    assign rx_data      = data_reg;
    assign rx_frame_err = err_reg;

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: accepts a byte on a uart_tx_en pulse while idle and
// holds uart_tx_busy high until the stop bit has completed.
module uart_tx #(
    parameter int BIT_RATE     = 4800,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);
    localparam int CPB   = CLK_HZ / BIT_RATE;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int IDX_W = $clog2(PAYLOAD_BITS);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t               state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic                    txd_reg;
    logic                    busy_reg;

    wire bit_end = (cnt_reg == CNT_W'(CPB - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= TX_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            cnt_reg <= bit_end ? '0 : cnt_reg + 1'b1;
            case (state_reg)
                TX_IDLE: begin
                    cnt_reg <= '0;
                    if (uart_tx_en) begin
                        shift_reg <= uart_tx_data;
                        txd_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= TX_START;
                    end
                end
                TX_START: if (bit_end) begin
                    txd_reg   <= shift_reg[0];
                    idx_reg   <= '0;
                    state_reg <= TX_DATA;
                end
                TX_DATA: if (bit_end) begin
                    if (idx_reg == IDX_W'(PAYLOAD_BITS - 1)) begin
                        txd_reg   <= 1'b1;
                        state_reg <= TX_STOP;
                    end else begin
                        shift_reg <= shift_reg >> 1;
                        txd_reg   <= shift_reg[1];
                        idx_reg   <= idx_reg + 1'b1;
                    end
                end
                default: if (bit_end) begin
                    busy_reg  <= 1'b0;
                    state_reg <= TX_IDLE;
                end
            endcase
        end
    end

    assign uart_txd     = txd_reg;
    assign uart_tx_busy = busy_reg;

endmodule

// File: rtl/dma_uart_host_mem.sv
// Host-side fp16 memory (128 words) served over UART 8N1 write/read frames.
// Optional inter-byte timeout on partial writes: define DMA_HOST_MEM_TIMEOUT_EN.
module dma_uart_host_mem
    import dma_uart_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int BIT_RATE      = 4800,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  uart_rxd,
    output logic                  uart_txd,
    output logic                  busy,
    input  logic [DMA_ADDR_W-1:0] peek_addr,
    output fp16_t                 peek_data,
    output logic [15:0]           wr_count,
    input  logic                  err_clr,
    output logic                  err_frame,
    output logic                  err_overrun,
    output logic                  err_timeout
);
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_frame_err;
    logic        tx_busy;
    cmd_t        cmd;

    host_state_t           state_reg;
    logic [DMA_ADDR_W-1:0] addr_reg;
    logic [7:0]            msb_reg;
    fp16_t                 rd_data_reg;
    fp16_t                 peek_data_reg;
    logic                  tx_en_reg;
    logic [7:0]            tx_data_reg;
    logic [15:0]           wr_count_reg;
    logic                  err_frame_reg;
    logic                  err_overrun_reg;
    fp16_t                 mem [DMA_DEPTH];

    assign cmd = cmd_t'(rx_data);

    wire in_read = (state_reg == ST_RD_FETCH) || (state_reg == ST_RD_MSB_0) ||
                   (state_reg == ST_RD_MSB_1) || (state_reg == ST_RD_MSB_2) ||
                   (state_reg == ST_RD_LSB_0) || (state_reg == ST_RD_LSB_1) ||
                   (state_reg == ST_RD_LSB_2);
    wire wr_en   = (state_reg == ST_WR_LSB) && rx_valid;

    uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) u_rx (
        .clk          (clk),
        .resetn       (resetn),
        .rxd          (uart_rxd),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err)
    );

    uart_tx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8)) u_tx (
        .clk          (clk),
        .resetn       (resetn),
        .uart_txd     (uart_txd),
        .uart_tx_busy (tx_busy),
        .uart_tx_en   (tx_en_reg),
        .uart_tx_data (tx_data_reg)
    );

    // Memory contents survive reset; address is stable through a read so the fetch needs no enable.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr_reg] <= {msb_reg, rx_data};
        rd_data_reg <= mem[addr_reg];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) peek_data_reg <= '0;
        else         peek_data_reg <= mem[peek_addr];
    end

`ifdef DMA_HOST_MEM_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_HZ / BIT_RATE);
    logic [31:0] to_cnt_reg;
    logic        err_timeout_reg;
    assign err_timeout = err_timeout_reg;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            msb_reg         <= '0;
            tx_en_reg       <= 1'b0;
            tx_data_reg     <= '0;
            wr_count_reg    <= '0;
            err_frame_reg   <= 1'b0;
            err_overrun_reg <= 1'b0;
`ifdef DMA_HOST_MEM_TIMEOUT_EN
            to_cnt_reg      <= '0;
            err_timeout_reg <= 1'b0;
`endif
        end else begin
            if (err_clr) begin
                err_frame_reg   <= 1'b0;
                err_overrun_reg <= 1'b0;
`ifdef DMA_HOST_MEM_TIMEOUT_EN
                err_timeout_reg <= 1'b0;
`endif
            end
            if (rx_valid && in_read) err_overrun_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: if (rx_valid) begin
                    addr_reg  <= cmd.addr;
                    state_reg <= rx_data[DMA_CMD_WE_BIT] ? ST_WR_MSB : ST_RD_FETCH;
                end
                ST_WR_MSB: if (rx_valid) begin
                    msb_reg   <= rx_data;
                    state_reg <= ST_WR_LSB;
                end
                ST_WR_LSB: if (rx_valid) begin
                    wr_count_reg <= wr_count_reg + 16'd1;
                    state_reg    <= ST_IDLE;
                end
                ST_RD_FETCH: state_reg <= ST_RD_MSB_0;
                ST_RD_MSB_0: begin
                    tx_en_reg   <= 1'b1;
                    tx_data_reg <= rd_data_reg[15:8];
                    state_reg   <= ST_RD_MSB_1;
                end
                ST_RD_MSB_1: begin
                    tx_en_reg <= 1'b0;
                    state_reg <= ST_RD_MSB_2;
                end
                ST_RD_MSB_2: if (!tx_busy) state_reg <= ST_RD_LSB_0;
                ST_RD_LSB_0: begin
                    tx_en_reg   <= 1'b1;
                    tx_data_reg <= rd_data_reg[7:0];
                    state_reg   <= ST_RD_LSB_1;
                end
                ST_RD_LSB_1: begin
                    tx_en_reg <= 1'b0;
                    state_reg <= ST_RD_LSB_2;
                end
                ST_RD_LSB_2: if (!tx_busy) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase

`ifdef DMA_HOST_MEM_TIMEOUT_EN
            if ((state_reg == ST_WR_MSB || state_reg == ST_WR_LSB) && !rx_valid) begin
                if (to_cnt_reg == TIMEOUT_CYCLES - 1) begin
                    to_cnt_reg      <= '0;
                    err_timeout_reg <= 1'b1;
                    state_reg       <= ST_IDLE;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 32'd1;
                end
            end else begin
                to_cnt_reg <= '0;
            end
`endif

            // A framing error abandons whatever frame or response was in flight.
            if (rx_frame_err) begin
                err_frame_reg <= 1'b1;
                tx_en_reg     <= 1'b0;
                state_reg     <= ST_IDLE;
            end
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign peek_data   = peek_data_reg;
    assign wr_count    = wr_count_reg;
    assign err_frame   = err_frame_reg;
    assign err_overrun = err_overrun_reg;

endmodule

// File: tb/tb_dma_uart_host_mem.sv
// Directed bench for dma_uart_host_mem: write/read frames, overrun, framing error,
// stalled partial write and reset behaviour, with a serial monitor on uart_txd.
module tb_dma_uart_host_mem;
    localparam int CLK_HZ   = 800;
    localparam int BIT_RATE = 100;
    localparam int CPB      = CLK_HZ / BIT_RATE;

    logic        clk = 1'b0;
    logic        resetn;
    logic        uart_rxd;
    logic        uart_txd;
    logic        busy;
    logic [6:0]  peek_addr;
    logic [15:0] peek_data;
    logic [15:0] wr_count;
    logic        err_clr;
    logic        err_frame;
    logic        err_overrun;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rx_q[$];

    dma_uart_host_mem #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .TIMEOUT_BYTES(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .uart_rxd    (uart_rxd),
        .uart_txd    (uart_txd),
        .busy        (busy),
        .peek_addr   (peek_addr),
        .peek_data   (peek_data),
        .wr_count    (wr_count),
        .err_clr     (err_clr),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Serial monitor: samples each txd byte at mid-bit and queues it.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && uart_txd === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic send_write(input logic [6:0] a, input logic [15:0] d);
        send_byte({1'b1, a}, 1'b1);
        send_byte(d[15:8], 1'b1);
        send_byte(d[7:0], 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic peek_chk(input string tag, input logic [6:0] a, input logic [15:0] exp);
        @(negedge clk);
        peek_addr = a;
        @(negedge clk);
        check(tag, 32'(peek_data), 32'(exp));
    endtask

    // Waits (bounded) for two response bytes, noting whether busy ever dropped.
    task automatic expect_response(input string tag, input logic [15:0] exp);
        int t = 0;
        logic busy_dropped = 1'b0;
        logic [7:0] b0, b1;
        while (rx_q.size() < 2 && t < 40 * CPB) begin
            @(negedge clk);
            if (!busy) busy_dropped = 1'b1;
            t++;
        end
        check({tag, " nbytes"}, 32'(rx_q.size()), 32'd2);
        check({tag, " busy held"}, 32'(busy_dropped), 32'd0);
        b0 = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        b1 = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        check({tag, " msb"}, 32'(b0), 32'(exp[15:8]));
        check({tag, " lsb"}, 32'(b1), 32'(exp[7:0]));
        t = 0;
        while (busy && t < 4 * CPB) begin
            @(negedge clk);
            t++;
        end
        check({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_err_clr;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " wr_count"}, 32'(wr_count), 32'd0);
        check({tag, " peek_data"}, 32'(peek_data), 32'd0);
        check({tag, " errs"}, 32'({err_frame, err_overrun, err_timeout}), 32'd0);
        check({tag, " txd"}, 32'(uart_txd), 32'd1);
    endtask

    initial begin
        resetn    = 1'b0;
        uart_rxd  = 1'b1;
        peek_addr = '0;
        err_clr   = 1'b0;
        repeat (4) @(negedge clk);
        reset_checks("reset");
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Single write then readback over the link
        send_write(7'd5, 16'h3C00);
        check("wr_count after 1 write", 32'(wr_count), 32'd1);
        peek_chk("peek mem[5]", 7'd5, 16'h3C00);
        send_byte(8'h05, 1'b1);
        expect_response("read 5", 16'h3C00);

        // Reset keeps memory; boundary addresses 127 and 0
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        peek_chk("mem[5] survives reset", 7'd5, 16'h3C00);
        send_write(7'd127, 16'h1234);
        send_write(7'd0, 16'h5678);
        peek_chk("peek mem[127]", 7'd127, 16'h1234);
        peek_chk("peek mem[0]", 7'd0, 16'h5678);
        check("wr_count after 2 writes", 32'(wr_count), 32'd2);

        // Byte arriving during response: overrun, response intact
        send_byte(8'h05, 1'b1);
        send_byte(8'h99, 1'b1);
        expect_response("overrun read 5", 16'h3C00);
        check("err_overrun set", 32'(err_overrun), 32'd1);
        pulse_err_clr();
        check("err_overrun cleared", 32'(err_overrun), 32'd0);

        // Framing error on MSB of a write frame
        send_write(7'd3, 16'h1111);
        send_byte(8'h83, 1'b1);
        send_byte(8'hAB, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("err_frame set", 32'(err_frame), 32'd1);
        check("busy after frame err", 32'(busy), 32'd0);
        check("wr_count after frame err", 32'(wr_count), 32'd3);
        peek_chk("mem[3] unchanged", 7'd3, 16'h1111);
        pulse_err_clr();
        check("err_frame cleared", 32'(err_frame), 32'd0);
        send_write(7'd3, 16'hABCD);
        peek_chk("mem[3] after rewrite", 7'd3, 16'hABCD);
        check("wr_count after rewrite", 32'(wr_count), 32'd4);

        // Stalled partial write
        send_write(7'd1, 16'h0007);
        send_byte(8'h81, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (50 * CPB) @(negedge clk);
`ifdef DMA_HOST_MEM_TIMEOUT_EN
        check("stall busy", 32'(busy), 32'd0);
        check("stall err_timeout", 32'(err_timeout), 32'd1);
`else
        check("stall busy", 32'(busy), 32'd1);
        check("stall err_timeout", 32'(err_timeout), 32'd0);
`endif
        check("stall wr_count", 32'(wr_count), 32'd5);
        peek_chk("stall mem[1]", 7'd1, 16'h0007);

        // Reset while a write frame is pending
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        reset_checks("midframe reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("busy after reset release", 32'(busy), 32'd0);
        peek_chk("mem[1] after reset", 7'd1, 16'h0007);
        check("no stray txd bytes", 32'(rx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
